// File: rtl/rv_pkg.sv
// Shared RV32 core definitions used by the register file slice.
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: issue sets, writeback clears, issue wins on collision.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_en_i,
  input  logic [AW-1:0]   iss_a_i,
  input  logic [NREG-1:0] clr_i,
  output logic [NREG-1:0] busy_o,
  output logic            any_busy_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            any_q;

  always_comb begin
    busy_d = busy_q & ~clr_i;
    if (iss_en_i && iss_a_i != AW'(REG_ZERO))
      busy_d[iss_a_i] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  // Summary flag is taken from next state so it is a pure flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      any_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      any_q  <= |busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign any_busy_o = any_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write bypass and busy scoreboard.
module reg_file_mp
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] RA,
  output logic [NRD*XLEN-1:0] RD,
  output logic [NRD-1:0]    RBUSY,
  input  logic [NWR*AW-1:0] WA,
  input  logic [NWR*XLEN-1:0] WD,
  input  logic [NWR-1:0]    WE,
  input  logic              ISS_EN,
  input  logic [AW-1:0]     ISS_A,
  output logic              ANY_BUSY
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] clr;
  logic [NREG-1:0] busy;

  // Ascending port loop: the highest-index port lands last and wins.
  always_comb begin
    mem_d = mem_q;
    clr   = '0;
    for (int j = 0; j < NWR; j++) begin
      if (WE[j] && WA[j*AW +: AW] != AW'(REG_ZERO)) begin
        mem_d[WA[j*AW +: AW]] = WD[j*XLEN +: XLEN];
        clr[WA[j*AW +: AW]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++)
        mem_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++)
        mem_q[k] <= mem_d[k];
    end
  end

  rf_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .iss_en_i   (ISS_EN),
    .iss_a_i    (ISS_A),
    .clr_i      (clr),
    .busy_o     (busy),
    .any_busy_o (ANY_BUSY)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            hit;

    assign ra = RA[i*AW +: AW];

    always_comb begin
      rd  = mem_q[ra];
      hit = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (WE[j] && WA[j*AW +: AW] == ra) begin
            rd  = WD[j*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
      end
      if (ra == AW'(REG_ZERO) || rst)
        rd = '0;
    end

    // A fresh issue to the same register keeps it busy despite the bypass.
    assign RD[i*XLEN +: XLEN] = rd;
    assign RBUSY[i] = busy[ra] &
                      ~(hit & ~(ISS_EN && ISS_A == ra));
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: bypass and non-bypass instances side by side.
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic [19:0] ra_a;
  logic [127:0] rd_a;
  logic [3:0]  rbusy_a;
  logic        any_a;
  logic [4:0]  ra_b;
  logic [31:0] rd_b;
  logic [0:0]  rbusy_b;
  logic        any_b;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [1:0]  we;
  logic        iss_en;
  logic [4:0]  iss_a;

  reg_file_mp #(
    .XLEN(32), .NREG(32), .NRD(4), .NWR(2), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .RA(ra_a), .RD(rd_a), .RBUSY(rbusy_a),
    .WA(wa), .WD(wd), .WE(we), .ISS_EN(iss_en), .ISS_A(iss_a),
    .ANY_BUSY(any_a)
  );

  reg_file_mp #(
    .XLEN(32), .NREG(32), .NRD(1), .NWR(2), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .RA(ra_b), .RD(rd_b), .RBUSY(rbusy_b),
    .WA(wa), .WD(wd), .WE(we), .ISS_EN(iss_en), .ISS_A(iss_a),
    .ANY_BUSY(any_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void push(int kind, int port, logic [31:0] v, string nm);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.exp  = v;
    e.nm   = nm;
    sbq.push_back(e);
  endfunction

  function automatic void exp_rd(int p, logic [31:0] v, string nm);
    push(0, p, v, nm);
  endfunction
  function automatic void exp_rb(int p, logic v, string nm);
    push(1, p, {31'd0, v}, nm);
  endfunction
  function automatic void exp_any(logic v, string nm);
    push(2, 0, {31'd0, v}, nm);
  endfunction
  function automatic void exp_rdb(logic [31:0] v, string nm);
    push(3, 0, v, nm);
  endfunction

  // Monitor: samples mid low-phase and drains everything queued so far.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.kind)
          0:       act = rd_a[e.port*32 +: 32];
          1:       act = {31'd0, rbusy_a[e.port]};
          2:       act = {31'd0, any_a};
          default: act = rd_b;
        endcase
        n_chk++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s port%0d: got %h, expected %h",
                   e.nm, e.port, act, e.exp);
        end
      end
    end
  end

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; we = '0; wa = '0; wd = '0;
    iss_en = 1'b0; iss_a = '0; ra_a = '0; ra_b = '0;

    // Reset state, with a write attempted while reset is held
    nx();
    we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF;
    ra_a = {4{5'd5}}; ra_b = 5'd5;
    for (int p = 0; p < 4; p++) begin
      exp_rd(p, 32'h0, "rst_rd");
      exp_rb(p, 1'b0, "rst_rbusy");
    end
    exp_any(1'b0, "rst_any");
    exp_rdb(32'h0, "rst_rd_nobyp");
    nx();
    rst = 1'b0; we = '0;
    exp_rd(0, 32'h0, "rst_write_lost");

    // Test 1: write x5, issue x3, then async reset mid-cycle
    nx();
    we = 2'b01; wd[31:0] = 32'hDEADBEEF;
    iss_en = 1'b1; iss_a = 5'd3;
    exp_rd(0, 32'hDEADBEEF, "t1_bypass");
    exp_rdb(32'h0, "t1_nobyp_old");
    nx();
    we = '0; iss_en = 1'b0;
    exp_rd(0, 32'hDEADBEEF, "t1_stored");
    exp_rdb(32'hDEADBEEF, "t1_nobyp_new");
    exp_any(1'b1, "t1_any_set");
    #3;
    rst = 1'b1;
    exp_rd(0, 32'h0, "t1_async_rd");
    exp_rdb(32'h0, "t1_async_rd_nobyp");
    exp_any(1'b0, "t1_async_any");
    nx();
    #3;
    rst = 1'b0;
    nx();
    exp_rd(0, 32'h0, "t1_x5_cleared");
    exp_any(1'b0, "t1_any_after");
    exp_rdb(32'h0, "t1_x5_nobyp");

    // Test 2: x0 write and issue are ignored
    nx();
    ra_a = '0;
    we = 2'b01; wa[4:0] = 5'd0; wd[31:0] = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_a = 5'd0;
    exp_rd(0, 32'h0, "t2_x0_rd");
    exp_rb(0, 1'b0, "t2_x0_busy");
    nx();
    we = '0; iss_en = 1'b0;
    exp_rd(0, 32'h0, "t2_x0_rd_next");
    exp_rb(0, 1'b0, "t2_x0_busy_next");
    exp_any(1'b0, "t2_any");

    // Test 3: two ports to x7, port 1 wins
    nx();
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
    ra_a[4:0] = 5'd7; ra_b = 5'd7;
    exp_rd(0, 32'h22, "t3_bypass_prio");
    exp_rdb(32'h0, "t3_nobyp_old");
    nx();
    we = '0;
    exp_rd(0, 32'h22, "t3_stored");
    exp_rdb(32'h22, "t3_nobyp_new");

    // Test 4: issue x9, hold busy, then clear by writeback
    nx();
    iss_en = 1'b1; iss_a = 5'd9; ra_a[4:0] = 5'd9;
    exp_rb(0, 1'b0, "t4_issue_cycle");
    for (int c = 0; c < 3; c++) begin
      nx();
      iss_en = 1'b0;
      exp_rb(0, 1'b1, "t4_busy_hold");
      exp_any(1'b1, "t4_any_hold");
    end
    nx();
    we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h40;
    exp_rb(0, 1'b0, "t4_wb_mask");
    exp_rd(0, 32'h40, "t4_wb_bypass");
    exp_any(1'b1, "t4_any_wb_cycle");
    nx();
    we = '0;
    exp_rb(0, 1'b0, "t4_cleared");
    exp_rd(0, 32'h40, "t4_stored");
    exp_any(1'b0, "t4_any_clear");

    // Test 5: write and re-issue of x9 in the same cycle
    nx();
    iss_en = 1'b1; iss_a = 5'd9;
    nx();
    we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h55;
    exp_rb(0, 1'b1, "t5_collide_busy");
    exp_rd(0, 32'h55, "t5_collide_rd");
    nx();
    we = '0; iss_en = 1'b0;
    exp_rb(0, 1'b1, "t5_set_wins");
    exp_rd(0, 32'h55, "t5_stored");
    exp_any(1'b1, "t5_any");
    nx();
    we = 2'b01; wd[31:0] = 32'h77;
    exp_rb(0, 1'b0, "t5_final_wb");
    exp_rd(0, 32'h77, "t5_final_rd");
    nx();
    we = '0;
    exp_rb(0, 1'b0, "t5_idle");
    exp_any(1'b0, "t5_any_idle");

    // Test 6: all four read ports on x12
    nx();
    ra_a = {4{5'd12}};
    we = 2'b01; wa = {5'd12, 5'd12}; wd[31:0] = 32'h6;
    for (int p = 0; p < 4; p++) exp_rd(p, 32'h6, "t6_rd_6");
    nx();
    wd[31:0] = 32'hA;
    for (int p = 0; p < 4; p++) exp_rd(p, 32'hA, "t6_rd_a");
    nx();
    we = 2'b10; wd[63:32] = 32'h3;
    for (int p = 0; p < 4; p++) exp_rd(p, 32'h3, "t6_port1_wr");
    nx();
    we = '0;
    for (int p = 0; p < 4; p++) begin
      exp_rd(p, 32'h3, "t6_stored");
      exp_rb(p, 1'b0, "t6_not_busy");
    end

    nx();
    #3;
    if (sbq.size() != 0) begin
      $display("FAIL drain: got %0d unchecked entries, expected 0",
               sbq.size());
      n_fail += sbq.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
